// File: rtl/apogeo_pkg.sv
// Shared trace types: serializer beat states, per-instruction status, stored entry layout.
// Build with TRACE_TIMESTAMP_EN to add a 32-bit write-cycle timestamp and a fourth beat.
package apogeo_pkg;

    localparam int INFO_W = 27;
    localparam int DEST_W = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        RESULT = 3'd2,
        INFO   = 3'd3,
        TIME   = 3'd4
    } trace_beat_t;

    typedef struct packed {
        logic       exception;
        logic [3:0] cause;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
    } instruction_status_t;

    typedef struct packed {
        logic [31:0]         address;
        logic [31:0]         result;
        logic [DEST_W-1:0]   destination;
        instruction_status_t info;
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0]         timestamp;
`endif
    } trace_entry_t;

`ifdef TRACE_TIMESTAMP_EN
    localparam int TRACE_BEATS = 4;
`else
    localparam int TRACE_BEATS = 3;
`endif

endpackage

// File: rtl/trace_interface.sv
// Write-back trace channel: producer presents one retired instruction per valid cycle, sink stalls when full.
interface trace_interface;
    import apogeo_pkg::*;

    logic                valid;
    logic [31:0]         address;
    logic [DEST_W-1:0]   destination;
    logic [31:0]         result;
    instruction_status_t info;
    logic                stall;

    modport master (output valid, address, destination, result, info, input stall);
    modport slave  (input valid, address, destination, result, info, output stall);
endinterface

// File: rtl/trace_fifo.sv
// DEPTH-entry synchronous FIFO of trace entries; push ignored when full, pop ignored when empty.
// Zero-latency head read; flush clears pointers and count and wins over push/pop.
module trace_fifo
    import apogeo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  trace_entry_t               entry_i,
    input  logic                       pop_i,
    output trace_entry_t               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("trace_fifo DEPTH must be a power of two and at least 2");
    end

    trace_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= entry_i;
    end

endmodule

// File: rtl/trace_buffer.sv
// Trace elastic buffer + beat serializer: first beat one cycle after the write lands, then 3 beats/entry
// (4 with TRACE_TIMESTAMP_EN); stall = full, beats held stable while out_ready_i is low.
module trace_buffer
    import apogeo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    trace_interface.slave          trace_channel,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [31:0]            out_data_o,
    output logic                   out_last_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    if ($bits(instruction_status_t) > INFO_W) begin : g_info_width_check
        $error("instruction_status_t must fit in 27 bits");
    end

    trace_beat_t   state_q, state_d;
    trace_entry_t  wr_entry, head;
    logic          fifo_full, fifo_empty, pop;
    logic [CW-1:0] fifo_count;
    logic          overflow_q, overflow_d;
    logic          handshake;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]   ts_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ts_q <= '0;
        else       ts_q <= ts_q + 32'd1;
    end
`endif

    always_comb begin
        wr_entry             = '0;
        wr_entry.address     = trace_channel.address;
        wr_entry.result      = trace_channel.result;
        wr_entry.destination = trace_channel.destination;
        wr_entry.info        = trace_channel.info;
`ifdef TRACE_TIMESTAMP_EN
        wr_entry.timestamp   = ts_q;
`endif
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (trace_channel.valid),
        .entry_i (wr_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign trace_channel.stall = fifo_full;
    assign count_o             = fifo_count;
    assign overflow_o          = overflow_q;
    assign handshake           = out_valid_o && out_ready_i;

    // A full-cycle write is lost even if the same cycle pops; flush discards it silently.
    always_comb begin
        overflow_d = overflow_q;
        if (flush_i)                                  overflow_d = 1'b0;
        else if (trace_channel.valid && fifo_full)    overflow_d = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        out_data_o  = '0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = ADDR;
            end
            ADDR: begin
                out_valid_o = 1'b1;
                out_data_o  = head.address;
                if (handshake) state_d = RESULT;
            end
            RESULT: begin
                out_valid_o = 1'b1;
                out_data_o  = head.result;
                if (handshake) state_d = INFO;
            end
            INFO: begin
                out_valid_o = 1'b1;
                out_data_o  = {INFO_W'(head.info), head.destination};
`ifdef TRACE_TIMESTAMP_EN
                if (handshake) state_d = TIME;
            end
            TIME: begin
                out_valid_o = 1'b1;
                out_data_o  = head.timestamp;
`endif
                out_last_o  = 1'b1;
                if (handshake) begin
                    pop     = 1'b1;
                    state_d = (fifo_count > CW'(1)) ? ADDR : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_trace_buffer.sv
// Directed + random bench for trace_buffer against a queue-of-entries reference model.
module tb_trace_buffer;
    import apogeo_pkg::*;

    localparam int DEPTH = 16;
    localparam int IW    = $bits(instruction_status_t);

    logic        clk = 1'b0;
    logic        rst, flush, ready;
    logic        out_valid, out_last, overflow;
    logic [31:0] out_data;
    logic [4:0]  count;

    trace_interface tch();

    always #5 clk = ~clk;

    trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .trace_channel (tch),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (ready),
        .out_data_o    (out_data),
        .out_last_o    (out_last),
        .count_o       (count),
        .overflow_o    (overflow)
    );

    int           tests = 0;
    int           fails = 0;
    trace_entry_t mq[$];
    int           beat_idx;
    logic         m_ovf;
    logic [31:0]  cyc;
    logic         held_vld;
    logic [31:0]  held_dat;
    logic         s_valid, s_stall;
    logic [31:0]  seen[$];
    logic         seen_last[$];
    trace_entry_t idle_e = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic trace_entry_t rand_entry();
        trace_entry_t e;
        logic [IW-1:0] iv;
        e             = '0;
        e.address     = $urandom;
        e.result      = $urandom;
        e.destination = 5'($urandom);
        iv            = IW'($urandom);
        e.info        = iv;
        return e;
    endfunction

    function automatic logic [31:0] beat_of(input trace_entry_t e, input int idx);
        logic [26:0] iw;
        iw = '0;
        iw[IW-1:0] = e.info;
        case (idx)
            0: return e.address;
            1: return e.result;
            2: return {iw, e.destination};
`ifdef TRACE_TIMESTAMP_EN
            3: return e.timestamp;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Called just after a rising edge; drives, samples at the falling edge, updates model at the next rise.
    task automatic tick(input logic v, input trace_entry_t e, input logic rdy, input logic fl);
        trace_entry_t we;
        int           size_before;
        tch.valid       = v;
        tch.address     = e.address;
        tch.result      = e.result;
        tch.destination = e.destination;
        tch.info        = e.info;
        ready           = rdy;
        flush           = fl;
        @(negedge clk);
        s_valid = out_valid;
        s_stall = tch.stall;
        size_before = mq.size();
        check("count", 32'(count), size_before);
        check("stall", 32'(tch.stall), 32'(size_before == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (held_vld) begin
            check("valid_held", 32'(out_valid), 1);
            check("data_held", out_data, held_dat);
        end
        if (!out_valid) check("last_when_idle", 32'(out_last), 0);
        if (out_valid && rdy && !fl) begin
            if (mq.size() == 0) begin
                check("beat_unexpected", 32'(out_valid), 0);
            end else begin
                check("beat_data", out_data, beat_of(mq[0], beat_idx));
                check("beat_last", 32'(out_last), 32'(beat_idx == TRACE_BEATS - 1));
                seen.push_back(out_data);
                seen_last.push_back(out_last);
                beat_idx++;
                if (beat_idx == TRACE_BEATS) begin
                    void'(mq.pop_front());
                    beat_idx = 0;
                end
            end
        end
        held_vld = out_valid && !rdy && !fl;
        held_dat = out_data;
        if (fl) begin
            mq.delete();
            beat_idx = 0;
            m_ovf    = 1'b0;
        end else if (v) begin
            if (size_before == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                we = e;
`ifdef TRACE_TIMESTAMP_EN
                we.timestamp = cyc;
`endif
                mq.push_back(we);
            end
        end
        @(posedge clk);
        cyc = cyc + 32'd1;
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((mq.size() != 0 || out_valid) && n < 300) begin
            tick(1'b0, idle_e, 1'b1, 1'b0);
            n++;
        end
        check({tag, "_drain_in_time"}, 32'(n < 300), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tch.valid = 1'b0;
        ready = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_data", out_data, 0);
        check("rst_count", 32'(count), 0);
        check("rst_stall", 32'(tch.stall), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst = 1'b0;
        mq.delete();
        beat_idx = 0;
        m_ovf    = 1'b0;
        held_vld = 1'b0;
        cyc      = 32'd0;
        @(posedge clk);
        cyc = 32'd1;
        #1;
    endtask

    initial begin
        trace_entry_t e;
        int n, run, maxrun, stalls, bad;

        tch.address = '0; tch.result = '0; tch.destination = '0; tch.info = '0;
        do_reset();

        // Single entry, ready high, with first-beat latency.
        seen.delete(); seen_last.delete();
        e = '0; e.address = 32'h100; e.result = 32'hDEADBEEF; e.destination = 5'd5;
        tick(1'b1, e, 1'b1, 1'b0);
        tick(1'b0, idle_e, 1'b1, 1'b0);
        check("t1_idle_after_write", 32'(s_valid), 0);
        tick(1'b0, idle_e, 1'b1, 1'b0);
        check("t1_first_beat_valid", 32'(s_valid), 1);
        drain("t1");
        check("t1_nbeats", seen.size(), TRACE_BEATS);
        check("t1_beat0", seen[0], 32'h100);
        check("t1_beat1", seen[1], 32'hDEADBEEF);
        check("t1_beat2", seen[2], 32'h5);
        check("t1_last0", 32'(seen_last[0]), 0);
        check("t1_last1", 32'(seen_last[1]), 0);
`ifndef TRACE_TIMESTAMP_EN
        check("t1_last2", 32'(seen_last[2]), 1);
`endif
        check("t1_count_back_to_0", 32'(count), 0);

        // Fill with ready low, then one more write while full.
        for (int i = 0; i < DEPTH; i++) tick(1'b1, rand_entry(), 1'b0, 1'b0);
        tick(1'b0, idle_e, 1'b0, 1'b0);
        check("t2_count_full", 32'(count), DEPTH);
        check("t2_stall_full", 32'(s_stall), 1);
        e = rand_entry(); e.address = 32'hBAD0BAD0;
        tick(1'b1, e, 1'b0, 1'b0);
        tick(1'b0, idle_e, 1'b0, 1'b0);
        check("t2_overflow_set", 32'(overflow), 1);
        seen.delete(); seen_last.delete();
        drain("t2");
        bad = 0;
        foreach (seen[k]) if (seen[k] == 32'hBAD0BAD0) bad++;
        check("t2_dropped_entry_absent", bad, 0);
        check("t2_beats_out", seen.size(), DEPTH * TRACE_BEATS);

        // Ready toggling mid-packet.
        seen.delete(); seen_last.delete();
        for (int i = 0; i < 3; i++) tick(1'b1, rand_entry(), 1'(i % 2), 1'b0);
        for (int k = 0; k < 30; k++) tick(1'b0, idle_e, 1'(k % 2 == 0), 1'b0);
        drain("t3");
        check("t3_handshakes", seen.size(), 3 * TRACE_BEATS);

        // Back-to-back entries, ready high: one unbroken run of beats.
        run = 0; maxrun = 0; stalls = 0;
        for (int k = 0; k < 14; k++) begin
            tick(1'(k < 2), rand_entry(), 1'b1, 1'b0);
            if (s_stall) stalls++;
            run = s_valid ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        check("t4_no_gap_run", maxrun, 2 * TRACE_BEATS);
        check("t4_no_stall", stalls, 0);
        drain("t4");

        // Flush during the RESULT beat together with a write.
        check("t5_overflow_before", 32'(overflow), 1);
        tick(1'b1, rand_entry(), 1'b1, 1'b0);
        n = 0;
        do begin
            tick(1'b0, idle_e, 1'b1, 1'b0);
            n++;
        end while (!s_valid && n < 10);
        check("t5_addr_seen", 32'(s_valid), 1);
        tick(1'b1, rand_entry(), 1'b1, 1'b1);
        tick(1'b0, idle_e, 1'b1, 1'b0);
        check("t5_valid_after_flush", 32'(s_valid), 0);
        check("t5_count_after_flush", 32'(count), 0);
        check("t5_overflow_after_flush", 32'(overflow), 0);

        // Reset mid-packet aborts immediately.
        tick(1'b1, rand_entry(), 1'b0, 1'b0);
        tick(1'b1, rand_entry(), 1'b0, 1'b0);
        tick(1'b0, idle_e, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_valid_on_reset", 32'(out_valid), 0);
        check("t6_count_on_reset", 32'(count), 0);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, idle_e, 1'b1, 1'b0);
            check("t6_no_resume", 32'(s_valid), 0);
        end

        // Random traffic with occasional flushes.
        for (int k = 0; k < 600; k++)
            tick(1'($urandom_range(0, 1)), rand_entry(), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 59) == 0));
        drain("t7");

`ifdef TRACE_TIMESTAMP_EN
        do_reset();
        seen.delete(); seen_last.delete();
        while (cyc < 32'd7) tick(1'b0, idle_e, 1'b1, 1'b0);
        tick(1'b1, rand_entry(), 1'b1, 1'b0);
        drain("t8");
        check("t8_ts_beat", seen[3], 32'd7);
        check("t8_ts_last", 32'(seen_last[3]), 1);
        check("t8_info_not_last", 32'(seen_last[2]), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
